seq_alu: RTL

- Parametrised, handshaked successor of the team's combinational 4-bit ALU.
- Same 3-bit opcode map, operand width set by WIDTH, full 2*WIDTH-bit result.
- Multiply is an iterative shift-add, taking WIDTH cycles; all other ops complete in one cycle.
- Valid/ready on both sides, so the block drops into streaming datapaths and testbench-driven pipelines.

---
 rtl/seq_alu_if.sv | 26 ++
 rtl/seq_alu.sv | 132 +++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Handshake bundle for seq_alu: operand/opcode request channel and result channel.
interface seq_alu_if #(
   parameter int WIDTH = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [2:0]           op;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   y;
   logic                 zero;
   logic                 borrow;
   logic                 busy;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, y, zero, borrow, busy
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, y, zero, borrow, busy
   );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU with WIDTH-bit unsigned operands and a 2*WIDTH-bit result.
// MUL is an iterative shift-add over WIDTH cycles; every other op takes one cycle.
module seq_alu #(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   seq_alu_if.slave   bus
);
   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [RW-1:0]   r_acc;
   logic [RW-1:0]   r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CW-1:0]   r_cnt;
   logic [RW-1:0]   r_y;
   logic            r_zero;
   logic            r_borrow;
   logic            r_out_valid;
   logic            r_busy;

   logic            w_in_ready;
   logic            w_accept;
   logic [RW-1:0]   w_alu;
   logic [RW-1:0]   w_acc_next;

   // Single-cycle ops on zero-extended operands; MUL is handled iteratively, so it falls to ADD here.
   function automatic logic [RW-1:0] alu_f(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
      logic [RW-1:0] ea;
      logic [RW-1:0] eb;
      ea = {{WIDTH{1'b0}}, a};
      eb = {{WIDTH{1'b0}}, b};
      case (op)
         3'b000:  alu_f = ea + eb;
         3'b001:  alu_f = ea - eb;
         3'b010:  alu_f = ea & eb;
         3'b011:  alu_f = ea | eb;
         3'b101:  alu_f = ea;
         3'b110:  alu_f = eb;
         3'b111:  alu_f = ea ^ eb;
         default: alu_f = ea + eb;
      endcase
   endfunction

   assign w_in_ready = (r_state == S_IDLE) && rst_n;
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_alu      = alu_f(bus.op, bus.a, bus.b);
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {RW{1'b0}});

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.y         = r_y;
   assign bus.zero      = r_zero;
   assign bus.borrow    = r_borrow;
   assign bus.busy      = r_busy;

   // Control FSM with datapath registers and registered result/flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= {RW{1'b0}};
         r_mcand     <= {RW{1'b0}};
         r_mplier    <= {WIDTH{1'b0}};
         r_cnt       <= {CW{1'b0}};
         r_y         <= {RW{1'b0}};
         r_zero      <= 1'b0;
         r_borrow    <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_busy <= 1'b1;
                  if (bus.op == OP_MUL) begin
                     r_acc    <= {RW{1'b0}};
                     r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                     r_mplier <= bus.b;
                     r_cnt    <= CW'(WIDTH);
                     r_state  <= S_MUL;
                  end else begin
                     r_y         <= w_alu;
                     r_zero      <= (w_alu == {RW{1'b0}});
                     r_borrow    <= (bus.op == OP_SUB) && (bus.a < bus.b);
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - CW'(1);
               // Last iteration: publish the accumulator including this cycle's partial product.
               if (r_cnt == CW'(1)) begin
                  r_y         <= w_acc_next;
                  r_zero      <= (w_acc_next == {RW{1'b0}});
                  r_borrow    <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end
endmodule
